// File: rtl/mux_scan_pkg.sv
// Shared types and default sizing for the scanning channel selector.
package mux_scan_pkg;

    localparam int DEF_N_IN     = 7;
    localparam int DEF_DATA_W   = 1;
    localparam int DEF_SCAN_DIV = 4;

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_SCAN   = 2'd1,
        ST_ERR    = 2'd2
    } state_t;

    // Index width for a range of n values, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_scan_ctr.sv
// Dwell counter plus wrapping channel-index register for mux_scan_sel.
module mux_scan_ctr
    import mux_scan_pkg::*;
#(
    parameter int N_IN       = DEF_N_IN,
    parameter int SCAN_DIV   = DEF_SCAN_DIV,
    localparam int SEL_W     = width_of(N_IN)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cnt_clr,
    input  logic             cnt_en,
    input  logic             idx_load,
    input  logic [SEL_W-1:0] idx_val,
    output logic [SEL_W-1:0] idx
);

    localparam int               CNT_W    = width_of(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N_IN - 1);

    logic [CNT_W-1:0] cnt;
    logic             dwell_done;

    assign dwell_done = cnt_en && (cnt == CNT_LAST);

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (cnt_clr || dwell_done) begin
            cnt <= '0;
        end else if (cnt_en) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx <= '0;
        end else if (idx_load) begin
            idx <= idx_val;
        end else if (dwell_done) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/mux_scan_sel.sv
// Registered N-way channel selector with manual load and timed auto-scan.
// Optional MUX_SCAN_HOLD_EN adds a hold input that freezes scanning.
module mux_scan_sel
    import mux_scan_pkg::*;
#(
    parameter int N_IN       = DEF_N_IN,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SCAN_DIV   = DEF_SCAN_DIV,
    localparam int SEL_W     = width_of(N_IN)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [N_IN*DATA_W-1:0] data_in,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   load,
    input  logic                   scan_en,
`ifdef MUX_SCAN_HOLD_EN
    input  logic                   hold,
`endif
    output logic [DATA_W-1:0]      data_out,
    output logic                   out_valid,
    output logic [SEL_W-1:0]       cur_idx,
    output logic                   sel_err
);

    localparam logic [SEL_W:0] N_IN_EXT = (SEL_W + 1)'(N_IN);

    state_t             state, state_next;
    logic               sel_legal;
    logic               freeze;
    logic               idx_load;
    logic [SEL_W-1:0]   idx_val;
    logic               cnt_en;
    logic               cnt_clr;
    logic               err_set;
    logic               valid_next;
    logic [DATA_W-1:0]  chan;

    assign sel_legal = ({1'b0, sel} < N_IN_EXT);
    assign chan      = data_in[int'(cur_idx)*DATA_W +: DATA_W];

`ifdef MUX_SCAN_HOLD_EN
    assign freeze = hold;
`else
    assign freeze = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_MANUAL;
        else         state <= state_next;
    end

    // Leaving ERR into SCAN takes priority over a simultaneous load.
    always_comb begin
        // NOTE: default first so no path through the case infers a latch.
        state_next = state;
        unique case (state)
            ST_MANUAL: begin
                if (scan_en)                state_next = ST_SCAN;
                else if (load && !sel_legal) state_next = ST_ERR;
            end
            ST_SCAN: begin
                if (!scan_en) state_next = ST_MANUAL;
            end
            ST_ERR: begin
                if (scan_en)                state_next = ST_SCAN;
                else if (load && sel_legal) state_next = ST_MANUAL;
            end
            default: state_next = ST_MANUAL;
        endcase
    end

    always_comb begin
        idx_load = 1'b0;
        idx_val  = sel;
        err_set  = 1'b0;
        unique case (state)
            ST_MANUAL: begin
                idx_load = load && sel_legal;
                err_set  = load && !sel_legal;
            end
            ST_ERR: begin
                if (scan_en) begin
                    idx_load = 1'b1;
                    idx_val  = '0;
                end else begin
                    idx_load = load && sel_legal;
                end
            end
            default: ;
        endcase
        cnt_clr    = (state != ST_SCAN);
        cnt_en     = (state == ST_SCAN) && scan_en && !freeze;
        valid_next = (state != ST_ERR) && (state_next != ST_ERR);
    end

    mux_scan_ctr #(
        .N_IN     (N_IN),
        .SCAN_DIV (SCAN_DIV)
    ) u_ctr (
        .clk      (clk),
        .resetn   (resetn),
        .cnt_clr  (cnt_clr),
        .cnt_en   (cnt_en),
        .idx_load (idx_load),
        .idx_val  (idx_val),
        .idx      (cur_idx)
    );

    // Output stays blanked for the first cycle after reset or after ERR.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_out  <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            data_out  <= valid_next ? chan : '0;
            out_valid <= valid_next;
            if (err_set) sel_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_scan_sel.sv
// Self-checking bench for mux_scan_sel against a cycle-level behavioural model.
// Define MUX_SCAN_HOLD_EN for both bench and RTL to exercise the hold input.
module tb_mux_scan_sel;

    localparam int N_IN     = 7;
    localparam int DATA_W   = 1;
    localparam int SCAN_DIV = 4;
    localparam int SEL_W    = 3;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic [N_IN*DATA_W-1:0] data_in;
    logic [SEL_W-1:0]       sel;
    logic                   load;
    logic                   scan_en;
    logic                   hold;
    logic [DATA_W-1:0]      data_out;
    logic                   out_valid;
    logic [SEL_W-1:0]       cur_idx;
    logic                   sel_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef enum {M_MANUAL, M_SCAN, M_ERR} mode_e;
    mode_e             m_mode;
    int                m_base;
    int                m_ticks;
    bit                m_sel_err;
    logic [SEL_W-1:0]  exp_idx;
    logic [DATA_W-1:0] exp_data;
    logic              exp_valid;
    logic              exp_err;

    mux_scan_sel #(.N_IN(N_IN), .DATA_W(DATA_W), .SCAN_DIV(SCAN_DIV)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .data_in   (data_in),
        .sel       (sel),
        .load      (load),
        .scan_en   (scan_en),
`ifdef MUX_SCAN_HOLD_EN
        .hold      (hold),
`endif
        .data_out  (data_out),
        .out_valid (out_valid),
        .cur_idx   (cur_idx),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Scan index is the starting channel advanced once per full dwell period.
    function automatic int model_idx();
        return (m_base + m_ticks / SCAN_DIV) % N_IN;
    endfunction

    task automatic model_reset();
        m_mode    = M_MANUAL;
        m_base    = 0;
        m_ticks   = 0;
        m_sel_err = 1'b0;
        exp_idx   = '0;
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
    endtask

    task automatic model_edge();
        mode_e old_mode;
        int    old_idx;
        bit    legal;
        old_mode = m_mode;
        old_idx  = model_idx();
        legal    = (int'(sel) < N_IN);
        case (old_mode)
            M_MANUAL: begin
                if (load && legal)  m_base = int'(sel);
                if (load && !legal) m_sel_err = 1'b1;
                if (scan_en)                m_mode = M_SCAN;
                else if (load && !legal)    m_mode = M_ERR;
            end
            M_ERR: begin
                if (scan_en) begin
                    m_base = 0;
                    m_mode = M_SCAN;
                end else if (load && legal) begin
                    m_base = int'(sel);
                    m_mode = M_MANUAL;
                end
            end
            M_SCAN: begin
                if (scan_en) begin
                    if (!hold) m_ticks++;
                end else begin
                    m_base  = old_idx;
                    m_ticks = 0;
                    m_mode  = M_MANUAL;
                end
            end
            default: ;
        endcase
        exp_valid = (old_mode != M_ERR) && (m_mode != M_ERR);
        exp_data  = exp_valid ? data_in[old_idx*DATA_W +: DATA_W] : '0;
        exp_idx   = SEL_W'(model_idx());
        exp_err   = m_sel_err;
    endtask

    // Advance one clock; inputs change only at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0; load = 1'b0; sel = '0; scan_en = 1'b0; hold = 1'b0; data_in = '0;
        model_reset();
        #12;
        n_checks += 4;
        if (cur_idx !== '0)   begin n_errors++; $display("FAIL reset cur_idx: got %0d want 0", cur_idx); end
        if (data_out !== '0)  begin n_errors++; $display("FAIL reset data_out: got %0h want 0", data_out); end
        if (out_valid !== 0)  begin n_errors++; $display("FAIL reset out_valid: got %0b want 0", out_valid); end
        if (sel_err !== 0)    begin n_errors++; $display("FAIL reset sel_err: got %0b want 0", sel_err); end
        @(negedge clk);
        resetn = 1'b1;
        tick();
        n_checks += 2;
        if (out_valid !== exp_valid) begin n_errors++; $display("FAIL post_reset out_valid: got %0b want %0b", out_valid, exp_valid); end
        if (cur_idx !== exp_idx)     begin n_errors++; $display("FAIL post_reset cur_idx: got %0d want %0d", cur_idx, exp_idx); end
    endtask

    task automatic test_manual_load();
        data_in = 7'b1010101;
        sel = 3'd2; load = 1'b1;
        tick();
        load = 1'b0;
        n_checks++;
        if (cur_idx !== exp_idx) begin n_errors++; $display("FAIL load cur_idx: got %0d want %0d", cur_idx, exp_idx); end
        tick();
        n_checks += 2;
        if (data_out !== exp_data)   begin n_errors++; $display("FAIL load data_out: got %0h want %0h", data_out, exp_data); end
        if (out_valid !== exp_valid) begin n_errors++; $display("FAIL load out_valid: got %0b want %0b", out_valid, exp_valid); end
    endtask

    task automatic test_sel_err();
        sel = 3'd7; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks += 4;
            if (sel_err !== exp_err)     begin n_errors++; $display("FAIL err sel_err: got %0b want %0b", sel_err, exp_err); end
            if (out_valid !== exp_valid) begin n_errors++; $display("FAIL err out_valid: got %0b want %0b", out_valid, exp_valid); end
            if (data_out !== exp_data)   begin n_errors++; $display("FAIL err data_out: got %0h want %0h", data_out, exp_data); end
            if (cur_idx !== exp_idx)     begin n_errors++; $display("FAIL err cur_idx: got %0d want %0d", cur_idx, exp_idx); end
            tick();
        end
        sel = 3'd3; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks += 3;
            if (out_valid !== exp_valid) begin n_errors++; $display("FAIL err_exit out_valid: got %0b want %0b", out_valid, exp_valid); end
            if (sel_err !== exp_err)     begin n_errors++; $display("FAIL err_exit sel_err: got %0b want %0b", sel_err, exp_err); end
            if (cur_idx !== exp_idx)     begin n_errors++; $display("FAIL err_exit cur_idx: got %0d want %0d", cur_idx, exp_idx); end
            tick();
        end
    endtask

    task automatic test_scan();
        sel = 3'd5; load = 1'b1;
        tick();
        load = 1'b0; scan_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data_in = N_IN'($urandom);
            tick();
            n_checks += 3;
            if (cur_idx !== exp_idx)     begin n_errors++; $display("FAIL scan cur_idx cyc %0d: got %0d want %0d", i, cur_idx, exp_idx); end
            if (data_out !== exp_data)   begin n_errors++; $display("FAIL scan data_out cyc %0d: got %0h want %0h", i, data_out, exp_data); end
            if (out_valid !== exp_valid) begin n_errors++; $display("FAIL scan out_valid cyc %0d: got %0b want %0b", i, out_valid, exp_valid); end
        end
    endtask

    task automatic test_scan_load_ignored();
        bit found = 1'b0;
        sel = 3'd1;
        for (int i = 0; i < 40 && !found; i++) begin
            load    = 1'($urandom);
            data_in = N_IN'($urandom);
            tick();
            n_checks++;
            if (cur_idx !== exp_idx) begin n_errors++; $display("FAIL scan_load cur_idx cyc %0d: got %0d want %0d", i, cur_idx, exp_idx); end
            found = (exp_idx == 3'd4);
        end
        load = 1'b0;
        n_checks++;
        if (!found) begin n_errors++; $display("FAIL scan_load reach_idx4: got timeout want index 4"); end
        scan_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks += 2;
            if (cur_idx !== exp_idx)   begin n_errors++; $display("FAIL scan_stop cur_idx: got %0d want %0d", cur_idx, exp_idx); end
            if (data_out !== exp_data) begin n_errors++; $display("FAIL scan_stop data_out: got %0h want %0h", data_out, exp_data); end
        end
    endtask

    task automatic test_async_reset();
        bit found = 1'b0;
        scan_en = 1'b1;
        for (int i = 0; i < 60 && !found; i++) begin
            data_in = N_IN'($urandom);
            tick();
            n_checks++;
            if (cur_idx !== exp_idx) begin n_errors++; $display("FAIL areset_pre cur_idx: got %0d want %0d", cur_idx, exp_idx); end
            found = (exp_idx == 3'd3);
        end
        n_checks++;
        if (!found) begin n_errors++; $display("FAIL areset reach_idx3: got timeout want index 3"); end
        #2 resetn = 1'b0;
        #1;
        n_checks += 4;
        if (cur_idx !== '0)  begin n_errors++; $display("FAIL areset cur_idx: got %0d want 0", cur_idx); end
        if (data_out !== '0) begin n_errors++; $display("FAIL areset data_out: got %0h want 0", data_out); end
        if (out_valid !== 0) begin n_errors++; $display("FAIL areset out_valid: got %0b want 0", out_valid); end
        if (sel_err !== 0)   begin n_errors++; $display("FAIL areset sel_err: got %0b want 0", sel_err); end
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_in = N_IN'($urandom);
            tick();
            n_checks += 3;
            if (cur_idx !== exp_idx)     begin n_errors++; $display("FAIL areset_scan cur_idx: got %0d want %0d", cur_idx, exp_idx); end
            if (data_out !== exp_data)   begin n_errors++; $display("FAIL areset_scan data_out: got %0h want %0h", data_out, exp_data); end
            if (out_valid !== exp_valid) begin n_errors++; $display("FAIL areset_scan out_valid: got %0b want %0b", out_valid, exp_valid); end
        end
    endtask

`ifdef MUX_SCAN_HOLD_EN
    task automatic test_hold();
        scan_en = 1'b0; sel = 3'd2; load = 1'b1;
        tick();
        load = 1'b0; scan_en = 1'b1;
        tick();
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_in[2] = ~data_in[2];
            tick();
            n_checks += 2;
            if (cur_idx !== exp_idx)   begin n_errors++; $display("FAIL hold cur_idx: got %0d want %0d", cur_idx, exp_idx); end
            if (data_out !== exp_data) begin n_errors++; $display("FAIL hold data_out: got %0h want %0h", data_out, exp_data); end
        end
        hold = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) scan_en = ~scan_en;
            load    = ($urandom_range(0, 3) == 0);
            sel     = SEL_W'($urandom_range(0, 7));
            data_in = N_IN'($urandom);
`ifdef MUX_SCAN_HOLD_EN
            hold    = ($urandom_range(0, 3) == 0);
`endif
            // Keep load and scan entry together only where the outcome is unambiguous.
            if (load && scan_en && m_mode == M_ERR) load = 1'b0;
            if (load && scan_en && m_mode == M_MANUAL) sel = SEL_W'($urandom_range(0, N_IN - 1));
            tick();
            n_checks += 4;
            if (cur_idx !== exp_idx)     begin n_errors++; $display("FAIL rand cur_idx cyc %0d: got %0d want %0d", i, cur_idx, exp_idx); end
            if (data_out !== exp_data)   begin n_errors++; $display("FAIL rand data_out cyc %0d: got %0h want %0h", i, data_out, exp_data); end
            if (out_valid !== exp_valid) begin n_errors++; $display("FAIL rand out_valid cyc %0d: got %0b want %0b", i, out_valid, exp_valid); end
            if (sel_err !== exp_err)     begin n_errors++; $display("FAIL rand sel_err cyc %0d: got %0b want %0b", i, sel_err, exp_err); end
        end
    endtask

    initial begin
        test_reset();
        test_manual_load();
        test_sel_err();
        test_scan();
        test_scan_load_ignored();
        test_async_reset();
`ifdef MUX_SCAN_HOLD_EN
        test_hold();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_scan_sel.md
MUX_SCAN_SEL -- requirements
Module: mux_scan_sel

Interface
REQ-001 Parameter N_IN, default 7, number of input channels (2..16).
REQ-002 Parameter DATA_W, default 1, bits per channel.
REQ-003 Parameter SCAN_DIV, default 4, clock cycles per channel dwell in scan mode (1..255).
REQ-004 Port clk  in  1  single rising-edge clock.
REQ-005 Port resetn  in  1  asynchronous, active-low reset.
REQ-006 Port data_in  in  N_IN*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
REQ-007 Port sel  in  SEL_W (= $clog2(N_IN), minimum 1)  manual channel index.
REQ-008 Port load  in  1  single-cycle strobe; latches sel into the active index.
REQ-009 Port scan_en  in  1  1 = auto-scan mode, 0 = manual mode.
REQ-010 Port data_out  out  DATA_W  registered selected channel.
REQ-011 Port out_valid  out  1  data_out reflects a legal channel.
REQ-012 Port cur_idx  out  SEL_W  active channel index.
REQ-013 Port sel_err  out  1  sticky flag: a load with sel >= N_IN occurred.

Function
REQ-014 FSM states SHALL be MANUAL, SCAN, ERR; encoding is in the shared package.
REQ-015 MANUAL: load with sel < N_IN SHALL set cur_idx = sel on that edge.
REQ-016 MANUAL: load with sel >= N_IN SHALL leave cur_idx unchanged, set sel_err, and enter ERR.
REQ-017 ERR: data_out SHALL be 0 and out_valid 0; a legal load SHALL return to MANUAL and clear out_valid-block but not sel_err.
REQ-018 sel_err SHALL clear only on reset.
REQ-019 scan_en=1 SHALL move MANUAL or ERR to SCAN on the next edge, with the dwell counter cleared and cur_idx unchanged (0 if leaving ERR).
REQ-020 SCAN: a dwell counter SHALL count 0..SCAN_DIV-1; at SCAN_DIV-1, cur_idx SHALL advance by 1, wrapping from N_IN-1 to 0.
REQ-021 SCAN: load SHALL be ignored.
REQ-022 scan_en=0 in SCAN SHALL return to MANUAL on the next edge, holding the current cur_idx.
REQ-023 data_out SHALL equal the channel of cur_idx as sampled one cycle earlier (1-cycle latency from an index change to data_out).
REQ-024 out_valid SHALL be 1 in MANUAL and SCAN once at least one cycle has elapsed since reset or since leaving ERR.
REQ-025 Simultaneous load and scan_en=1 in MANUAL SHALL apply the load first, then enter SCAN from the loaded index.

Reset
REQ-026 On resetn=0: state MANUAL, cur_idx 0, dwell counter 0, data_out 0, out_valid 0, sel_err 0, all asynchronously.
REQ-027 Reset deassertion mid-scan SHALL restart in MANUAL regardless of scan_en; SCAN is entered on the first edge after release if scan_en=1.

Configuration
REQ-028 Macro MUX_SCAN_HOLD_EN, when defined, SHALL add input port hold (1 bit), which freezes the dwell counter and cur_idx in SCAN while data_out keeps tracking data_in of the frozen channel.
REQ-029 Without MUX_SCAN_HOLD_EN, the hold port SHALL be absent and scanning SHALL be uninterruptible except via scan_en or reset.

Structure
REQ-030 Package mux_scan_pkg SHALL hold the FSM state typedef/localparams and the default N_IN, DATA_W, SCAN_DIV constants.
REQ-031 Sub-module mux_scan_ctr (dwell counter plus wrapping index counter) SHALL be the single child instance; the mux datapath and FSM stay in the top.

Verification
REQ-032 Reset, then N_IN=7, DATA_W=1, data_in=7'b1010101, load sel=2 -> cur_idx=2 next edge, data_out=1 one edge later, out_valid=1.
REQ-033 Load sel=7 (N_IN=7) -> sel_err=1, out_valid=0, data_out=0; then load sel=3 -> out_valid=1, sel_err stays 1.
REQ-034 scan_en=1, SCAN_DIV=4, starting at cur_idx=5 -> cur_idx sequence 5,6,0,1 changing every 4 cycles; data_out follows with 1-cycle lag.
REQ-035 Load asserted during SCAN with sel=1 -> ignored, scan sequence unchanged; drop scan_en at cur_idx=4 -> MANUAL, cur_idx holds 4.
REQ-036 resetn pulsed low mid-scan at cur_idx=3 -> all outputs 0 immediately, without waiting for a clock edge; after release with scan_en=1 -> SCAN from index 0.
REQ-037 With MUX_SCAN_HOLD_EN: hold=1 for 10 cycles at cur_idx=2 -> cur_idx stays 2; toggling data_in channel 2 appears on data_out 1 cycle later.
